burst_gate_gen: RTL and testbench

//  Generates the colour-burst gate for the chroma loop filter, from the raw composite ADC sample stream.
//  - Slices sync tips against a threshold.
//  - Width-qualifies each sync pulse, so equalising and broad (vsync) pulses are rejected.
//  - After each valid hsync, waits out the breezeway and asserts burst_active for a fixed window.
//  - Tracks line period and reports horizontal lock.

---
 rtl/burst_gate_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_burst_gate_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_gate_gen.sv
// ---------------------------------------------------------------------------
// burst_gate_gen
//
// Builds the colour-burst gate for the chroma loop filter directly from the
// raw composite ADC sample stream. Sync tips are sliced against a threshold
// and only pulses of horizontal-sync width are accepted, so equalising and
// broad (vsync) pulses are ignored. After each accepted hsync the breezeway
// is waited out and the burst gate is raised for a fixed window. The line
// period between accepted hsyncs is tracked to report horizontal lock.
//
// Ports
//   clk           in   sample clock, one sample per cycle
//   rst           in   asynchronous, active-high reset
//   sample_in     in   composite video sample, unsigned, SAMPLE_W bits
//   burst_active  out  burst gate, BURST_LEN consecutive cycles per valid line
//   hsync_pulse   out  one-cycle strobe per width-qualified hsync
//   line_locked   out  horizontal timing lock status
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module burst_gate_gen #(
  parameter int SAMPLE_W     = 12,
  parameter int SYNC_THRESH  = 400,
  parameter int SYNC_MIN     = 40,
  parameter int SYNC_MAX     = 100,
  parameter int BURST_DELAY  = 12,
  parameter int BURST_LEN    = 32,
  parameter int LINE_MIN     = 850,
  parameter int LINE_MAX     = 970,
  parameter int LOCK_LINES   = 4,
  parameter int LINE_TIMEOUT = 16384
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                burst_active,
  output logic                hsync_pulse,
  output logic                line_locked
);

  // Width counter saturates one above SYNC_MAX so that over-long pulses stay
  // distinguishable from a valid maximum-width pulse.
  localparam int WIDTH_W = $clog2(SYNC_MAX + 2);
  localparam int CNT_MAX = (BURST_DELAY > BURST_LEN) ? BURST_DELAY : BURST_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LINE_W  = 15;
  localparam int RUN_W   = $clog2(LOCK_LINES + 1);

  localparam logic [SAMPLE_W-1:0] THRESH_V    = SAMPLE_W'(SYNC_THRESH);
  localparam logic [WIDTH_W-1:0]  WIDTH_ONE   = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0]  WIDTH_MIN_V = WIDTH_W'(SYNC_MIN);
  localparam logic [WIDTH_W-1:0]  WIDTH_MAX_V = WIDTH_W'(SYNC_MAX);
  localparam logic [WIDTH_W-1:0]  WIDTH_SAT_V = WIDTH_W'(SYNC_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]    DELAY_LAST  = CNT_W'(BURST_DELAY - 1);
  localparam logic [CNT_W-1:0]    BURST_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [LINE_W-1:0]   LINE_ONE    = LINE_W'(1);
  localparam logic [LINE_W-1:0]   LINE_MIN_V  = LINE_W'(LINE_MIN);
  localparam logic [LINE_W-1:0]   LINE_MAX_V  = LINE_W'(LINE_MAX);
  localparam logic [LINE_W-1:0]   LINE_TO_V   = LINE_W'(LINE_TIMEOUT);
  localparam logic [RUN_W-1:0]    RUN_ONE     = RUN_W'(1);
  localparam logic [RUN_W-1:0]    RUN_LOCK_V  = RUN_W'(LOCK_LINES);

  typedef enum logic [2:0] {
    SEARCH    = 3'd0,
    WAIT_FALL = 3'd1,
    IN_SYNC   = 3'd2,
    PORCH     = 3'd3,
    BURST     = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [WIDTH_W-1:0]   width_r, width_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [LINE_W-1:0]    line_r, line_s;
  logic [RUN_W-1:0]     run_r, run_s;
  logic                 have_ref_r, have_ref_s;
  logic                 locked_s;
  logic                 below_s;
  logic                 valid_s;
  logic                 in_window_s;

  assign below_s     = (sample_in < THRESH_V);
  assign in_window_s = (line_r >= LINE_MIN_V) && (line_r <= LINE_MAX_V);

  // Sync slicer / width qualifier / porch-and-burst sequencer.
  always_comb begin
    state_s = state_r;
    width_s = width_r;
    cnt_s   = cnt_r;
    valid_s = 1'b0;
    case (state_r)
      // Only arm once the line is above threshold, so a sync already in
      // progress when reset released is never measured.
      SEARCH: begin
        if (!below_s) begin
          state_s = WAIT_FALL;
        end else begin
          state_s = SEARCH;
        end
      end
      WAIT_FALL: begin
        if (below_s) begin
          state_s = IN_SYNC;
          width_s = WIDTH_ONE;
        end else begin
          state_s = WAIT_FALL;
        end
      end
      IN_SYNC: begin
        if (below_s) begin
          if (width_r < WIDTH_SAT_V) begin
            width_s = width_r + WIDTH_ONE;
          end else begin
            width_s = width_r;
          end
        end else begin
          // First sample back above threshold: qualify the pulse width.
          if ((width_r >= WIDTH_MIN_V) && (width_r <= WIDTH_MAX_V)) begin
            valid_s = 1'b1;
            state_s = PORCH;
            cnt_s   = '0;
          end else begin
            state_s = WAIT_FALL;
          end
        end
      end
      // Porch and burst are blind to the input: noise here cannot retrigger.
      PORCH: begin
        if (cnt_r == DELAY_LAST) begin
          state_s = BURST;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      BURST: begin
        if (cnt_r == BURST_LAST) begin
          state_s = WAIT_FALL;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = SEARCH;
        width_s = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // Line period measurement and lock run tracking.
  always_comb begin
    line_s     = line_r;
    run_s      = run_r;
    have_ref_s = have_ref_r;
    locked_s   = line_locked;
    if (line_r < LINE_TO_V) begin
      line_s = line_r + LINE_ONE;
    end else begin
      line_s = line_r;
    end
    // A valid hsync takes priority over a timeout landing in the same cycle.
    if (valid_s) begin
      line_s     = '0;
      have_ref_s = 1'b1;
      // Without a previous reference the period is meaningless; just restart.
      if (have_ref_r) begin
        if (in_window_s) begin
          if (run_r < RUN_LOCK_V) begin
            run_s = run_r + RUN_ONE;
          end else begin
            run_s = run_r;
          end
          if (run_s == RUN_LOCK_V) begin
            locked_s = 1'b1;
          end else begin
            locked_s = line_locked;
          end
        end else begin
          // Half-line and broad pulses reset the run but keep existing lock.
          run_s = '0;
        end
      end else begin
        run_s = run_r;
      end
    end else if (line_r == LINE_TO_V) begin
      locked_s   = 1'b0;
      run_s      = '0;
      have_ref_s = 1'b0;
    end else begin
      locked_s = line_locked;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= SEARCH;
      width_r      <= '0;
      cnt_r        <= '0;
      line_r       <= '0;
      run_r        <= '0;
      have_ref_r   <= 1'b0;
      hsync_pulse  <= 1'b0;
      burst_active <= 1'b0;
      line_locked  <= 1'b0;
    end else begin
      state_r      <= state_s;
      width_r      <= width_s;
      cnt_r        <= cnt_s;
      line_r       <= line_s;
      run_r        <= run_s;
      have_ref_r   <= have_ref_s;
      hsync_pulse  <= valid_s;
      // Gate follows the BURST state exactly, registered.
      burst_active <= (state_s == BURST);
      line_locked  <= locked_s;
    end
  end

endmodule

// File: tb/tb_burst_gate_gen.sv
module tb_burst_gate_gen;

  localparam int SYNC_THRESH  = 400;
  localparam int SYNC_MIN     = 40;
  localparam int SYNC_MAX     = 100;
  localparam int BD           = 12;
  localparam int BL           = 32;
  localparam int LINE_MIN     = 850;
  localparam int LINE_MAX     = 970;
  localparam int LOCK_LINES   = 4;
  localparam int TO           = 16384;
  localparam logic [11:0] LO  = 12'd100;
  localparam logic [11:0] HI  = 12'd1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] sample_in = 12'd1000;
  logic        burst_active, hsync_pulse, line_locked;

  burst_gate_gen dut (
    .clk(clk), .rst(rst), .sample_in(sample_in),
    .burst_active(burst_active), .hsync_pulse(hsync_pulse), .line_locked(line_locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: event view of the line, not a state machine.
  bit m_armed;      // seen the line above threshold since reset
  int m_low;        // length of the current low run (saturating)
  int m_blind_end;  // last cycle of porch+burst during which input is ignored
  int m_bs, m_be;   // expected burst window (cycle numbers)
  int m_last;       // cycle of last accepted hsync (-1 = reset point)
  bit m_have_ref;
  int m_run;
  bit m_lock;
  bit e_hs, e_lock;

  // Observations for directed sequences.
  int hs_cnt, b_cnt, last_hs, first_b, last_b, line_r;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_low = 0; m_blind_end = -1; m_bs = -100; m_be = -200;
    m_last = -1; m_have_ref = 1'b0; m_run = 0; m_lock = 1'b0;
    e_hs = 1'b0; e_lock = 1'b0;
  endtask

  // Evaluate the sample of cycle t; produces expectations for cycle t+1.
  task automatic model_eval(input int t, input logic [11:0] s);
    bit low, valid;
    int period;
    low = (int'(s) < SYNC_THRESH);
    valid = 1'b0;
    if (!m_armed) begin
      if (!low) m_armed = 1'b1;
    end else if (t <= m_blind_end) begin
      m_low = 0;
    end else if (low) begin
      if (m_low < SYNC_MAX + 1) m_low++;
    end else begin
      if (m_low >= SYNC_MIN && m_low <= SYNC_MAX) begin
        valid = 1'b1;
        m_bs = t + 1 + BD;
        m_be = t + BD + BL;
        m_blind_end = t + BD + BL;
      end
      m_low = 0;
    end
    period = t - m_last - 1;
    if (period > TO) period = TO;
    if (valid) begin
      if (m_have_ref) begin
        if (period >= LINE_MIN && period <= LINE_MAX) begin
          if (m_run < LOCK_LINES) m_run++;
          if (m_run == LOCK_LINES) m_lock = 1'b1;
        end else begin
          m_run = 0;
        end
      end
      m_have_ref = 1'b1;
      m_last = t;
    end else if (period == TO) begin
      m_lock = 1'b0; m_run = 0; m_have_ref = 1'b0;
    end
    e_hs = valid;
    e_lock = m_lock;
  endtask

  task automatic clr_obs();
    hs_cnt = 0; b_cnt = 0; last_hs = -1; first_b = -1; last_b = -1;
  endtask

  // One clock: drive, model, clock, sample #1 after the edge and compare.
  task automatic step(input logic [11:0] s);
    sample_in = s;
    model_eval(cyc, s);
    @(posedge clk);
    #1;
    cyc++;
    check("hsync_pulse", int'(hsync_pulse), int'(e_hs));
    check("burst_active", int'(burst_active), int'((cyc >= m_bs) && (cyc <= m_be)));
    check("line_locked", int'(line_locked), int'(e_lock));
    if (hsync_pulse) begin hs_cnt++; last_hs = cyc; end
    if (burst_active) begin
      if (b_cnt == 0) first_b = cyc;
      b_cnt++;
      last_b = cyc;
    end
  endtask

  // Called #1 after an edge; asserts reset between edges and checks it bites at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_burst", int'(burst_active), 0);
    check("rst_hsync", int'(hsync_pulse), 0);
    check("rst_lock", int'(line_locked), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  // Sync of w clocks, then high until period clocks after the sync fall.
  // Optional low dips of length dl at offsets d0/d1 from the first high sample.
  task automatic line(input int w, input int period, input int d0, input int d1, input int dl);
    for (int i = 0; i < w; i++) step(LO);
    line_r = cyc;
    for (int i = 0; i < period - w; i++) begin
      if ((d0 >= 0 && i >= d0 && i < d0 + dl) || (d1 >= 0 && i >= d1 && i < d1 + dl))
        step(LO);
      else
        step(HI);
    end
  endtask

  typedef struct {
    int w;
    int hs;
    int bc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{39, 0, 0};
    vecs[1] = '{40, 1, BL};
    vecs[2] = '{100, 1, BL};
    vecs[3] = '{101, 0, 0};
    vecs[4] = '{150, 0, 0};
    vecs[5] = '{2, 0, 0};

    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Test 1: basic line timing.
    repeat (5) step(HI);
    clr_obs();
    line(67, 300, -1, -1, 0);
    check("t1_hs_count", hs_cnt, 1);
    check("t1_hs_offset", last_hs - line_r, 1);
    check("t1_burst_first", first_b - line_r, 13);
    check("t1_burst_last", last_b - line_r, 44);
    check("t1_burst_len", b_cnt, 32);

    // Test 2: width qualification boundaries.
    for (int i = 0; i < 6; i++) begin
      clr_obs();
      line(vecs[i].w, 400, -1, -1, 0);
      check("t2_hs_count", hs_cnt, vecs[i].hs);
      check("t2_burst_len", b_cnt, vecs[i].bc);
    end

    // Test 3/4: lock acquisition, half-line retention, timeout, re-acquire.
    do_reset();
    repeat (5) step(HI);
    for (int i = 0; i < 6; i++) begin
      line(67, 910, -1, -1, 0);
      check("t3_lock", int'(line_locked), (i >= 4) ? 1 : 0);
    end
    line(67, 455, -1, -1, 0);
    check("t4_lock_kept", int'(line_locked), 1);
    line(67, 910, -1, -1, 0);
    check("t4_lock_after", int'(line_locked), 1);
    repeat (15000) step(HI);
    check("t3_pre_timeout", int'(line_locked), 1);
    repeat (1500) step(HI);
    check("t3_timeout", int'(line_locked), 0);
    for (int i = 0; i < 5; i++) begin
      line(67, 910, -1, -1, 0);
      check("t3_relock", int'(line_locked), (i == 4) ? 1 : 0);
    end

    // Test 5a: reset mid-burst truncates the gate immediately.
    for (int i = 0; i < 67; i++) step(LO);
    repeat (20) step(HI);
    check("t5_in_burst", int'(burst_active), 1);
    do_reset();
    // Test 5b: reset during a sync; partial sync after release is ignored.
    repeat (5) step(HI);
    for (int i = 0; i < 30; i++) step(LO);
    do_reset();
    clr_obs();
    for (int i = 0; i < 50; i++) step(LO);
    repeat (100) step(HI);
    check("t5_partial_ignored", hs_cnt, 0);
    line(60, 300, -1, -1, 0);
    check("t5_next_accepted", hs_cnt, 1);
    check("t5_next_burst", b_cnt, BL);

    // Test 6: noise during porch and burst is not seen.
    clr_obs();
    line(67, 400, 5, 25, 3);
    check("t6_hs_count", hs_cnt, 1);
    check("t6_burst_first", first_b - line_r, 13);
    check("t6_burst_len", b_cnt, BL);

    // Randomized lines against the model.
    do_reset();
    repeat (3) step(HI);
    for (int i = 0; i < 30; i++) begin
      int w, p, d0, d1, dl;
      w  = $urandom_range(110, 30);
      p  = ($urandom_range(9, 0) < 7) ? 910 : $urandom_range(1000, 400);
      d0 = ($urandom_range(1, 0) == 1) ? $urandom_range(200, 0) : -1;
      d1 = ($urandom_range(3, 0) == 0) ? $urandom_range(300, 0) : -1;
      dl = $urandom_range(5, 1);
      line(w, p, d0, d1, dl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
